// File: rtl/order_feed_arbiter_if.sv
// Bundles the feed, parser and downstream object signals of order_feed_arbiter.
//   feed_valid/feed_data/feed_pop        : N_FEEDS message buffers (head + pop pulse)
//   parser_buffer_text/parser_not_empty  : message and accept request to the parser
//   parser_ready/parser_out_object       : parser handshake and parsed result
//   obj_valid/obj_ready/obj_data/obj_src : downstream valid/ready object channel
//   msg_count/err_timeout                : delivered-object counter and sticky timeout flag
// master: arbiter view; slave: environment view.
interface order_feed_arbiter_if #(
  parameter int unsigned N_FEEDS = 4,
  parameter int unsigned MSG_W   = 320,
  parameter int unsigned OBJ_W   = 162,
  parameter int unsigned COUNT_W = 32
);
  localparam int unsigned IDX_W = (N_FEEDS > 1) ? $clog2(N_FEEDS) : 1;

  logic [N_FEEDS-1:0]       feed_valid;
  logic [N_FEEDS*MSG_W-1:0] feed_data;
  logic [N_FEEDS-1:0]       feed_pop;
  logic [MSG_W-1:0]         parser_buffer_text;
  logic                     parser_not_empty;
  logic                     parser_ready;
  logic [OBJ_W-1:0]         parser_out_object;
  logic                     obj_valid;
  logic                     obj_ready;
  logic [OBJ_W-1:0]         obj_data;
  logic [IDX_W-1:0]         obj_src;
  logic [COUNT_W-1:0]       msg_count;
  logic                     err_timeout;

  modport master (
    input  feed_valid, feed_data, parser_ready, parser_out_object, obj_ready,
    output feed_pop, parser_buffer_text, parser_not_empty,
           obj_valid, obj_data, obj_src, msg_count, err_timeout
  );

  modport slave (
    output feed_valid, feed_data, parser_ready, parser_out_object, obj_ready,
    input  feed_pop, parser_buffer_text, parser_not_empty,
           obj_valid, obj_data, obj_src, msg_count, err_timeout
  );
endinterface

// File: rtl/order_feed_arbiter.sv
// Round-robin scheduler sharing one order_book_parser among N_FEEDS message buffers.
// Pops the winning feed's message, sequences the parser accept handshake, then
// presents the parsed object downstream tagged with its source feed.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : order_feed_arbiter_if.master (feeds, parser, downstream, status)
module order_feed_arbiter #(
  parameter int unsigned N_FEEDS = 4,
  parameter int unsigned MSG_W   = 320,
  parameter int unsigned OBJ_W   = 162,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned COUNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  order_feed_arbiter_if.master  bus
);
  localparam int unsigned IDX_W = (N_FEEDS > 1) ? $clog2(N_FEEDS) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   rr_ptr, grant_idx;
  logic [MSG_W-1:0]   hold;
  logic [TO_W-1:0]    to_cnt;
  logic               obj_valid;
  logic [OBJ_W-1:0]   obj_data;
  logic [IDX_W-1:0]   obj_src;
  logic [COUNT_W-1:0] msg_count;
  logic               err_timeout;

  // Round-robin search: rotate requests so bit k is feed (rr_ptr+1+k) mod N.
  logic [2*N_FEEDS-1:0] req_dbl;
  logic [N_FEEDS-1:0]   rot;
  logic [N_FEEDS:0]     found;
  logic [IDX_W-1:0]     enc [N_FEEDS+1];
  logic [SUM_W-1:0]     shift_c, sum_c;
  logic [IDX_W-1:0]     grant_c;
  logic [MSG_W-1:0]     feed_msg [N_FEEDS];

  assign req_dbl  = {bus.feed_valid, bus.feed_valid};
  assign shift_c  = SUM_W'(rr_ptr) + SUM_W'(1);
  assign rot      = N_FEEDS'(req_dbl >> shift_c);
  assign found[0] = 1'b0;
  assign enc[0]   = '0;

  for (genvar g = 0; g < N_FEEDS; g++) begin : g_arb
    assign found[g+1]  = found[g] | rot[g];
    assign enc[g+1]    = enc[g] | ((rot[g] & ~found[g]) ? IDX_W'(g) : '0);
    assign feed_msg[g] = bus.feed_data[g*MSG_W +: MSG_W];
  end

  // Offset back to an absolute index; at most one wrap is possible.
  assign sum_c   = shift_c + SUM_W'(enc[N_FEEDS]);
  assign grant_c = (sum_c >= SUM_W'(N_FEEDS)) ? IDX_W'(sum_c - SUM_W'(N_FEEDS))
                                              : IDX_W'(sum_c);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  logic               take, to_inc, to_clr, to_fire, capture, deliver;
  logic [N_FEEDS-1:0] pop_c;

  // Next-state and control strobes
  always_comb begin
    state_d = state;
    take    = 1'b0;
    to_inc  = 1'b0;
    to_clr  = 1'b0;
    to_fire = 1'b0;
    capture = 1'b0;
    deliver = 1'b0;
    pop_c   = '0;
    case (state)
      S_IDLE: begin
        if (found[N_FEEDS]) begin
          take    = 1'b1;
          pop_c   = N_FEEDS'(1) << grant_c;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_ISSUE;
      S_ISSUE: begin
        if (bus.parser_ready) begin
          to_clr  = 1'b1;
          state_d = S_WAIT;
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          to_clr  = 1'b1;
          to_fire = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_inc  = 1'b1;
        end
      end
      S_WAIT: begin
        capture = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.obj_ready) begin
          deliver = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= IDX_W'(N_FEEDS - 1);
      grant_idx   <= '0;
      hold        <= '0;
      to_cnt      <= '0;
      obj_valid   <= 1'b0;
      obj_data    <= '0;
      obj_src     <= '0;
      msg_count   <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (take) begin
        hold      <= feed_msg[grant_c];
        grant_idx <= grant_c;
        rr_ptr    <= grant_c;
      end
      if (to_clr)      to_cnt <= '0;
      else if (to_inc) to_cnt <= to_cnt + TO_W'(1);
      if (to_fire) err_timeout <= 1'b1;
      if (capture) begin
        obj_data  <= bus.parser_out_object;
        obj_src   <= grant_idx;
        obj_valid <= 1'b1;
      end
      if (deliver) begin
        obj_valid <= 1'b0;
        msg_count <= msg_count + COUNT_W'(1);
      end
    end
  end

  // Pop is combinational; masked so it reads 0 while reset is asserted.
  assign bus.feed_pop           = reset ? '0 : pop_c;
  assign bus.parser_buffer_text = hold;
  assign bus.parser_not_empty   = (state == S_ISSUE);
  assign bus.obj_valid          = obj_valid;
  assign bus.obj_data           = obj_data;
  assign bus.obj_src            = obj_src;
  assign bus.msg_count          = msg_count;
  assign bus.err_timeout        = err_timeout;
endmodule

// File: tb/tb_order_feed_arbiter.sv
// Directed bench for order_feed_arbiter with a behavioural parser model.
module tb_order_feed_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned MW = 320;
  localparam int unsigned OW = 162;
  localparam int unsigned TO = 64;
  localparam int unsigned CW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  order_feed_arbiter_if #(.N_FEEDS(N), .MSG_W(MW), .OBJ_W(OW), .COUNT_W(CW)) bus ();

  order_feed_arbiter #(
    .N_FEEDS(N), .MSG_W(MW), .OBJ_W(OW), .TIMEOUT(TO), .COUNT_W(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  function automatic logic [MW-1:0] mk_msg(input int unsigned tag);
    logic [MW-1:0] m;
    for (int w = 0; w < MW / 32; w++) m[w*32 +: 32] = tag * 32'h9E37_79B1 + 32'(w);
    return m;
  endfunction

  function automatic logic [OW-1:0] parse(input logic [MW-1:0] m);
    return m[OW-1:0] ^ m[MW-1 -: OW] ^ OW'(32'hC0FF_EE11);
  endfunction

  // Parser model: registers the text, updates its object on an accepted request.
  logic [MW-1:0] text_q;
  always @(posedge clk) begin
    text_q <= bus.parser_buffer_text;
    if (bus.parser_not_empty && bus.parser_ready) bus.parser_out_object <= parse(text_q);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_obj(input string tag, input int unsigned src, input int unsigned tag_msg);
    chk({tag, "_valid"}, MW'(bus.obj_valid), MW'(1'b1));
    chk({tag, "_src"},   MW'(bus.obj_src),   MW'(src));
    chk({tag, "_data"},  MW'(bus.obj_data),  MW'(parse(mk_msg(tag_msg))));
  endtask

  initial begin
    bus.feed_valid   = '0;
    bus.obj_ready    = 1'b0;
    bus.parser_ready = 1'b0;
    for (int i = 0; i < N; i++) bus.feed_data[i*MW +: MW] = mk_msg(i + 1);

    // Reset state
    repeat (3) tick();
    chk("rst_pop",   MW'(bus.feed_pop),           MW'(0));
    chk("rst_valid", MW'(bus.obj_valid),          MW'(0));
    chk("rst_count", MW'(bus.msg_count),          MW'(0));
    chk("rst_err",   MW'(bus.err_timeout),        MW'(0));
    chk("rst_ne",    MW'(bus.parser_not_empty),   MW'(0));
    chk("rst_text",  bus.parser_buffer_text,      MW'(0));
    reset = 1'b0;

    // 1: single message from feed 0, latency 4 from pop to obj_valid
    bus.parser_ready = 1'b1;
    bus.obj_ready    = 1'b1;
    bus.feed_valid   = 4'b0001;
    #1;
    chk("t1_pop", MW'(bus.feed_pop), MW'(4'b0001));
    tick(); bus.feed_valid = '0;
    chk("t1_load_pop", MW'(bus.feed_pop),         MW'(0));
    chk("t1_text",     bus.parser_buffer_text,    mk_msg(1));
    chk("t1_load_ne",  MW'(bus.parser_not_empty), MW'(0));
    tick();
    chk("t1_issue_ne", MW'(bus.parser_not_empty), MW'(1));
    tick();
    chk("t1_wait_ne",    MW'(bus.parser_not_empty), MW'(0));
    chk("t1_wait_valid", MW'(bus.obj_valid),        MW'(0));
    tick();
    chk_obj("t1", 0, 1);
    tick();
    chk("t1_count", MW'(bus.msg_count), MW'(1));
    chk("t1_done",  MW'(bus.obj_valid), MW'(0));

    // 2: all feeds valid, fresh reset -> grants 0,1,2,3,0,1 every 5 clks
    reset = 1'b1; #2; reset = 1'b0;
    chk("t2_count0", MW'(bus.msg_count), MW'(0));
    bus.feed_valid = '1;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t2_pop%0d", k), MW'(bus.feed_pop), MW'(4'b0001 << (k % 4)));
      repeat (4) tick();
      chk_obj($sformatf("t2_obj%0d", k), k % 4, (k % 4) + 1);
      tick();
    end
    bus.feed_valid = '0;
    chk("t2_count", MW'(bus.msg_count), MW'(6));

    // 3: downstream stall holds the object; no pops while busy
    bus.obj_ready  = 1'b0;
    bus.feed_valid = '1;
    #1;
    chk("t3_pop", MW'(bus.feed_pop), MW'(4'b0100));
    repeat (4) tick();
    for (int c = 0; c < 10; c++) begin
      chk_obj($sformatf("t3_hold%0d", c), 2, 3);
      chk($sformatf("t3_nopop%0d", c), MW'(bus.feed_pop), MW'(0));
      tick();
    end
    bus.obj_ready  = 1'b1;
    bus.feed_valid = '0;
    tick();
    chk("t3_count",   MW'(bus.msg_count), MW'(7));
    chk("t3_release", MW'(bus.obj_valid), MW'(0));
    tick();
    chk("t3_count_once", MW'(bus.msg_count), MW'(7));

    // 4: parser never ready -> timeout after 64 ISSUE clocks, then recover
    bus.parser_ready = 1'b0;
    bus.feed_valid   = 4'b0001;
    #1;
    chk("t4_pop", MW'(bus.feed_pop), MW'(4'b0001));
    tick(); bus.feed_valid = '0;
    tick();
    repeat (TO - 1) tick();
    chk("t4_last_ne",  MW'(bus.parser_not_empty), MW'(1));
    chk("t4_last_err", MW'(bus.err_timeout),      MW'(0));
    tick();
    chk("t4_err",   MW'(bus.err_timeout),      MW'(1));
    chk("t4_ne",    MW'(bus.parser_not_empty), MW'(0));
    chk("t4_valid", MW'(bus.obj_valid),        MW'(0));
    chk("t4_count", MW'(bus.msg_count),        MW'(7));
    repeat (3) tick();
    chk("t4_idle_valid", MW'(bus.obj_valid), MW'(0));
    bus.parser_ready = 1'b1;
    bus.feed_valid   = 4'b0010;
    #1;
    chk("t4_next_pop", MW'(bus.feed_pop), MW'(4'b0010));
    tick(); bus.feed_valid = '0;
    repeat (3) tick();
    chk_obj("t4_next", 1, 2);
    tick();
    chk("t4_next_count", MW'(bus.msg_count),   MW'(8));
    chk("t4_sticky",     MW'(bus.err_timeout), MW'(1));

    // 5: asynchronous reset in WAIT, then first grant is feed 0
    bus.feed_valid = 4'b0100;
    #1;
    tick(); bus.feed_valid = '0;
    tick(); tick();
    chk("t5_in_wait", MW'(bus.parser_not_empty), MW'(0));
    #2; reset = 1'b1; #1;
    chk("t5_valid", MW'(bus.obj_valid),        MW'(0));
    chk("t5_data",  MW'(bus.obj_data),         MW'(0));
    chk("t5_src",   MW'(bus.obj_src),          MW'(0));
    chk("t5_count", MW'(bus.msg_count),        MW'(0));
    chk("t5_err",   MW'(bus.err_timeout),      MW'(0));
    chk("t5_ne",    MW'(bus.parser_not_empty), MW'(0));
    chk("t5_text",  bus.parser_buffer_text,    MW'(0));
    bus.feed_valid = '1;
    #1;
    chk("t5_rst_pop", MW'(bus.feed_pop), MW'(0));
    reset = 1'b0;
    #1;
    chk("t5_pop", MW'(bus.feed_pop), MW'(4'b0001));
    tick(); bus.feed_valid = '0;
    repeat (3) tick();
    chk_obj("t5", 0, 1);
    tick();
    chk("t5_count1", MW'(bus.msg_count), MW'(1));

    // 6: 4-bit counter wraps: 17 deliveries since reset -> 1
    bus.feed_valid = '1;
    repeat (75) tick();
    chk("t6_wrap0", MW'(bus.msg_count), MW'(0));
    repeat (5) tick();
    chk("t6_wrap1", MW'(bus.msg_count), MW'(1));
    bus.feed_valid = '0;
    tick();
    chk("t6_idle", MW'(bus.obj_valid), MW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
